// File: rtl/div_pkg.sv
// div_pkg: shared width, counter width and FSM state type for the sequential divider
package div_pkg;
    localparam int W = 4;
    localparam int CW = $clog2(2 * W);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
module div_step
    import div_pkg::*;
(
    input  logic [W:0]   r,
    input  logic         dbit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   r_next,
    output logic         qbit
);
    logic [W+1:0] sh;
    // shift the next dividend bit in, subtract when the divisor fits
    always_comb begin
        sh = {r, dbit};
        qbit = sh >= (W+2)'(divisor);
        r_next = (W+1)'(qbit ? sh - (W+2)'(divisor) : sh);
    end
endmodule

// File: rtl/div8by4_seq.sv
// div8by4_seq: 8-by-4 unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides
module div8by4_seq
    import div_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div0
);
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] dvd_q, dvd_d, quo_q, quo_d;
    logic [W:0]     r_q, r_d, r_next;
    logic [W-1:0]   dvs_q, dvs_d, rem_q, rem_d;
    logic           div0_q, div0_d, qbit;

    div_step u_step (
        .r       (r_q),
        .dbit    (dvd_q[2*W-1]),
        .divisor (dvs_q),
        .r_next  (r_next),
        .qbit    (qbit)
    );

    // next state: latch operands on accept, shift quotient bits into dvd, capture result on the last step
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        dvd_d = dvd_q;
        r_d = r_q;
        dvs_d = dvs_q;
        quo_d = quo_q;
        rem_d = rem_q;
        div0_d = div0_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = RUN;
                dvd_d = dividend;
                dvs_d = divisor;
                r_d = '0;
                cnt_d = '0;
            end
            RUN: begin
                dvd_d = {dvd_q[2*W-2:0], qbit};
                r_d = r_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(2 * W - 1)) begin
                    state_d = DONE;
                    div0_d = dvs_q == '0;
                    quo_d = div0_d ? '1 : dvd_d;
                    rem_d = div0_d ? '0 : r_next[W-1:0];
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset discards any in-flight division
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            dvd_q <= '0;
            r_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            div0_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            dvd_q <= dvd_d;
            r_q <= r_d;
            dvs_q <= dvs_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            div0_q <= div0_d;
        end
    end

    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign quotient = quo_q;
    assign remainder = rem_q;
    assign div0 = div0_q;
endmodule

// File: tb/tb_div8by4_seq.sv
// tb_div8by4_seq: directed self-checking bench for the sequential divider
module tb_div8by4_seq;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready, div0;
    logic [7:0] dividend, quotient;
    logic [3:0] divisor, remainder;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_t[$];

    div8by4_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    // cycle stamp of every accepting edge
    always @(posedge clk) begin
        cyc++;
        if (in_valid && in_ready && !rst) acc_t.push_back(cyc);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic divide(input logic [7:0] a, input logic [3:0] b, input logic [7:0] eq,
                          input logic [3:0] er, input logic ed, input string tag);
        int n;
        @(negedge clk);
        chk({tag, " in_ready"}, in_ready, 1);
        in_valid = 1;
        dividend = a;
        divisor = b;
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        dividend = 8'hA5;
        divisor = 4'h3;
        wait_done(n);
        chk({tag, " latency"}, n, 8);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div0"}, div0, ed);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " out_valid drop"}, out_valid, 0);
        chk({tag, " in_ready rise"}, in_ready, 1);
    endtask

    initial begin
        int n;
        logic seen;
        rst = 1;
        in_valid = 0;
        out_ready = 0;
        dividend = 0;
        divisor = 0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        chk("reset div0", div0, 0);
        rst = 0;

        divide(8'd200, 4'd13, 8'd15, 4'd5, 1'b0, "200/13");

        @(negedge clk);
        acc_t.delete();
        in_valid = 1;
        dividend = 8'd255;
        divisor = 4'd1;
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        wait_done(n);
        chk("b2b first latency", n, 8);
        chk("b2b 255/1 quotient", quotient, 8'd255);
        chk("b2b 255/1 remainder", remainder, 0);
        chk("b2b in_ready in DONE", in_ready, 0);
        dividend = 8'd225;
        divisor = 4'd15;
        @(posedge clk);
        @(negedge clk);
        chk("b2b idle in_ready", in_ready, 1);
        wait_done(n);
        in_valid = 0;
        chk("b2b second latency", n, 9);
        chk("b2b 225/15 quotient", quotient, 8'd15);
        chk("b2b 225/15 remainder", remainder, 0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b accept count", acc_t.size(), 2);
        if (acc_t.size() == 2) chk("b2b accept spacing", acc_t[1] - acc_t[0], 10);

        divide(8'd100, 4'd0, 8'hFF, 4'd0, 1'b1, "100/0");
        divide(8'd9, 4'd3, 8'd3, 4'd0, 1'b0, "9/3");

        @(negedge clk);
        in_valid = 1;
        dividend = 8'd77;
        divisor = 4'd6;
        out_ready = 0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        wait_done(n);
        chk("bp latency", n, 8);
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", out_valid, 1);
            chk("bp quotient", quotient, 8'd12);
            chk("bp remainder", remainder, 4'd5);
            chk("bp in_ready", in_ready, 0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("bp release in_ready", in_ready, 1);
        chk("bp release out_valid", out_valid, 0);

        @(negedge clk);
        in_valid = 1;
        dividend = 8'd200;
        divisor = 4'd13;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("midrst in_ready", in_ready, 1);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst quotient", quotient, 0);
        chk("midrst remainder", remainder, 0);
        chk("midrst div0", div0, 0);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("midrst no result", seen, 0);
        divide(8'd50, 4'd7, 8'd7, 4'd1, 1'b0, "50/7");

        for (int a = 0; a < 16; a++)
            for (int b = 1; b < 16; b++)
                divide(8'(a * b), 4'(b), 8'(a), 4'd0, 1'b0, $sformatf("inv %0d*%0d", a, b));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
